splash_sprite_controller: RTL and testbench

//  Upstream stage for the 50x50 splash sprite image setter. On a fruit-slice event it latches the

---
 rtl/splash_sprite_controller_pkg.sv | 22 ++
 rtl/splash_sprite_controller_if.sv | 24 ++
 rtl/splash_sprite_controller_delay_line.sv | 31 +++
 rtl/splash_sprite_controller.sv | 95 +++++++++
 tb/tb_splash_sprite_controller.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/splash_sprite_controller_pkg.sv
// Shared splash constants, FSM encoding and the origin clamp helper.
// Screen/sprite geometry matches the image setters that consume splash_x/splash_y.
package splash_sprite_controller_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int SPRITE_W = 50;
  localparam int SPRITE_H = 50;
  localparam int MAX_X    = SCREEN_W - SPRITE_W;
  localparam int MAX_Y    = SCREEN_H - SPRITE_H;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    FADE = 2'd2
  } splash_state_e;

  function automatic logic [10:0] clamp11(input logic [10:0] v, input logic [10:0] lim);
    return (v < lim) ? v : lim;
  endfunction

endpackage

// File: rtl/splash_sprite_controller_if.sv
// Slice/pixel inputs and sprite origin/mask outputs of the splash controller.
// master drives slice and pixel position; slave is the controller.
interface splash_sprite_controller_if;
  logic       frame_tick;
  logic       slice;
  logic [9:0] slice_x;
  logic [8:0] slice_y;
  logic [9:0] pix_x;
  logic [8:0] pix_y;
  logic [9:0] splash_x;
  logic [8:0] splash_y;
  logic       in_box;
  logic       active;

  modport master (
    output frame_tick, slice, slice_x, slice_y, pix_x, pix_y,
    input  splash_x, splash_y, in_box, active
  );

  modport slave (
    input  frame_tick, slice, slice_x, slice_y, pix_x, pix_y,
    output splash_x, splash_y, in_box, active
  );
endinterface

// File: rtl/splash_sprite_controller_delay_line.sv
// 1-bit shift register of DEPTH stages, cleared by synchronous reset; DEPTH=0 is a wire.
// Latency DEPTH cycles, no backpressure.
module splash_delay_line #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic d_i,
  output logic q_o
);

  if (DEPTH == 0) begin : g_bypass
    assign q_o = d_i;
  end else begin : g_pipe
    logic [DEPTH-1:0] shift_q;

    always_ff @(posedge clk) begin
      if (!resetn) begin
        shift_q <= '0;
      end else begin
        shift_q[0] <= d_i;
        for (int i = 1; i < DEPTH; i++) begin
          shift_q[i] <= shift_q[i-1];
        end
      end
    end

    assign q_o = shift_q[DEPTH-1];
  end

endmodule

// File: rtl/splash_sprite_controller.sv
// Splash sprite lifecycle: latch clamped origin on slice, SHOW with drift, blinking FADE, IDLE.
// in_box lags the pixel position by PIPE_LAT cycles; no backpressure, events are single-cycle pulses.
module splash_sprite_controller
  import splash_sprite_controller_pkg::*;
#(
  parameter int SHOW_FRAMES = 45,
  parameter int FADE_FRAMES = 16,
  parameter int DRIFT_DIV   = 4,
  parameter int PIPE_LAT    = 2
) (
  input  logic                        clk,
  input  logic                        resetn,
  splash_sprite_controller_if.slave   bus
);

  splash_state_e state_q;
  logic [7:0]    frame_cnt_q;
  logic [3:0]    drift_cnt_q;
  logic [9:0]    splash_x_q;
  logic [8:0]    splash_y_q;
  logic          active_q;

  logic [9:0]    clamp_x_d;
  logic [8:0]    clamp_y_d;
  logic [8:0]    drift_y_d;
  logic          vis;
  logic          hit;

  assign clamp_x_d = 10'(clamp11({1'b0, bus.slice_x}, 11'(MAX_X)));
  assign clamp_y_d = 9'(clamp11({2'b0, bus.slice_y}, 11'(MAX_Y)));
  assign drift_y_d = (splash_y_q < 9'(MAX_Y)) ? splash_y_q + 9'd1 : splash_y_q;

  // slice has priority over frame_tick, so a coincident tick is dropped
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= IDLE;
      frame_cnt_q <= '0;
      drift_cnt_q <= '0;
      splash_x_q  <= '0;
      splash_y_q  <= '0;
      active_q    <= 1'b0;
    end else if (bus.slice) begin
      state_q     <= SHOW;
      frame_cnt_q <= '0;
      drift_cnt_q <= '0;
      splash_x_q  <= clamp_x_d;
      splash_y_q  <= clamp_y_d;
      active_q    <= 1'b1;
    end else if (bus.frame_tick && state_q != IDLE) begin
      if (drift_cnt_q == 4'(DRIFT_DIV - 1)) begin
        drift_cnt_q <= '0;
        splash_y_q  <= drift_y_d;
      end else begin
        drift_cnt_q <= drift_cnt_q + 4'd1;
      end
      if (state_q == SHOW && frame_cnt_q == 8'(SHOW_FRAMES - 1)) begin
        state_q     <= FADE;
        frame_cnt_q <= '0;
      end else if (state_q == FADE && frame_cnt_q == 8'(FADE_FRAMES - 1)) begin
        state_q     <= IDLE;
        frame_cnt_q <= '0;
        active_q    <= 1'b0;
      end else begin
        frame_cnt_q <= frame_cnt_q + 8'd1;
      end
    end
  end

  always_comb begin
    vis = 1'b0;
    case (state_q)
      SHOW:    vis = 1'b1;
      FADE:    vis = ~frame_cnt_q[0];
      default: vis = 1'b0;
    endcase
  end

  assign hit = vis
             && ({1'b0, bus.pix_x} >= {1'b0, splash_x_q})
             && ({1'b0, bus.pix_x} <  {1'b0, splash_x_q} + 11'(SPRITE_W))
             && ({2'b0, bus.pix_y} >= {2'b0, splash_y_q})
             && ({2'b0, bus.pix_y} <  {2'b0, splash_y_q} + 11'(SPRITE_H));

  splash_delay_line #(.DEPTH(PIPE_LAT)) u_in_box_dly (
    .clk    (clk),
    .resetn (resetn),
    .d_i    (hit),
    .q_o    (bus.in_box)
  );

  assign bus.splash_x = splash_x_q;
  assign bus.splash_y = splash_y_q;
  assign bus.active   = active_q;

endmodule

// File: tb/tb_splash_sprite_controller.sv
// Bench: directed scenarios plus random traffic, every cycle compared against a tick-count model.
module tb_splash_sprite_controller;

  localparam int SHOW = 45;
  localparam int FADE = 16;
  localparam int DIV  = 4;
  localparam int ENDT = SHOW + FADE;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  splash_sprite_controller_if bus();

  splash_sprite_controller #(
    .SHOW_FRAMES(SHOW), .FADE_FRAMES(FADE), .DRIFT_DIV(DIV), .PIPE_LAT(2)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 0;

  // Model: lifetime measured in frame ticks since the last slice
  int m_ticks  = ENDT;
  int m_x      = 0;
  int m_y0     = 0;
  bit m_sliced = 0;
  bit hist [2] = '{0, 0};

  function automatic int m_phase();  // 0 idle, 1 show, 2 fade
    if (m_ticks < SHOW) return 1;
    if (m_ticks < ENDT) return 2;
    return 0;
  endfunction

  function automatic int m_y();
    int y;
    if (!m_sliced) return 0;
    y = m_y0 + m_ticks / DIV;
    return (y > 430) ? 430 : y;
  endfunction

  function automatic bit m_hit(input int px, input int py);
    bit vis;
    vis = (m_phase() == 1) || (m_phase() == 2 && ((m_ticks - SHOW) % 2 == 0));
    return vis && px >= m_x && px < m_x + 50 && py >= m_y() && py < m_y() + 50;
  endfunction

  always @(posedge clk) begin
    if (!resetn) begin
      m_ticks = ENDT; m_x = 0; m_y0 = 0; m_sliced = 0;
      hist[0] = 0; hist[1] = 0;
    end else begin
      hist[1] = hist[0];
      hist[0] = m_hit(int'(bus.pix_x), int'(bus.pix_y));
      if (bus.slice) begin
        m_x  = (int'(bus.slice_x) > 590) ? 590 : int'(bus.slice_x);
        m_y0 = (int'(bus.slice_y) > 430) ? 430 : int'(bus.slice_y);
        m_ticks = 0; m_sliced = 1;
      end else if (bus.frame_tick && m_ticks < ENDT) begin
        m_ticks++;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("model splash_x", 32'(bus.splash_x), 32'(m_x));
      chk("model splash_y", 32'(bus.splash_y), 32'(m_y()));
      chk("model active",   32'(bus.active),   32'(m_phase() != 0));
      chk("model in_box",   32'(bus.in_box),   32'(hist[1]));
    end
  end

  task automatic step();
    @(posedge clk); #1;
    bus.frame_tick = 0;
    bus.slice = 0;
  endtask

  task automatic do_slice(input int x, input int y, input bit with_tick);
    bus.slice_x = 10'(x); bus.slice_y = 9'(y);
    bus.slice = 1; bus.frame_tick = with_tick;
    step();
  endtask

  task automatic do_ticks(input int n);
    repeat (n) begin
      bus.frame_tick = 1; step(); step();
    end
  endtask

  int obs [54];
  int cnt;

  initial begin
    bus.frame_tick = 0; bus.slice = 1; bus.slice_x = 10'd300; bus.slice_y = 9'd300;
    bus.pix_x = 10'd0; bus.pix_y = 9'd0;

    // 1: reset held with slice asserted
    @(posedge clk); #1; check_en = 1;
    repeat (4) begin bus.slice = 1; @(posedge clk); #1; end
    chk("reset active", 32'(bus.active), 0);
    chk("reset in_box", 32'(bus.in_box), 0);
    chk("reset splash_x", 32'(bus.splash_x), 0);
    chk("reset splash_y", 32'(bus.splash_y), 0);
    bus.slice = 0; resetn = 1; step();

    // 2: full lifecycle with the pixel parked inside the box
    bus.pix_x = 10'd120; bus.pix_y = 9'd212;
    do_slice(100, 200, 0);
    chk("life active after slice", 32'(bus.active), 1);
    chk("life origin x", 32'(bus.splash_x), 100);
    do_ticks(45);
    chk("life active in fade", 32'(bus.active), 1);
    chk("life y after 45", 32'(bus.splash_y), 211);
    do_ticks(16);
    chk("life active end", 32'(bus.active), 0);
    chk("life y end", 32'(bus.splash_y), 215);

    // 3: clamp at bottom-right
    do_slice(620, 470, 0);
    chk("clamp x", 32'(bus.splash_x), 590);
    chk("clamp y", 32'(bus.splash_y), 430);
    do_ticks(8);
    chk("clamp drift sat", 32'(bus.splash_y), 430);

    // 4: retrigger, second slice coincides with a tick that must be ignored
    do_slice(100, 100, 0);
    do_ticks(10);
    do_slice(300, 50, 1);
    chk("retrig x", 32'(bus.splash_x), 300);
    chk("retrig y", 32'(bus.splash_y), 50);
    bus.pix_x = 10'd320; bus.pix_y = 9'd70;
    do_ticks(46);
    step();
    chk("retrig fade frame1 hidden", 32'(bus.in_box), 0);
    chk("retrig y drift", 32'(bus.splash_y), 61);

    // 5: mask sweep and latency
    do_slice(100, 100, 0);
    bus.pix_y = 9'd100;
    for (int i = 0; i < 54; i++) begin
      bus.pix_x = (i <= 51) ? 10'(99 + i) : 10'd0;
      @(negedge clk); obs[i] = int'(bus.in_box);
      @(posedge clk); #1;
    end
    cnt = 0;
    for (int i = 0; i < 54; i++) cnt += obs[i];
    chk("sweep count", 32'(cnt), 50);
    chk("sweep pix99", 32'(obs[2]), 0);
    chk("sweep pix100", 32'(obs[3]), 1);
    chk("sweep pix149", 32'(obs[52]), 1);
    chk("sweep pix150", 32'(obs[53]), 0);
    bus.pix_y = 9'd150;
    cnt = 0;
    for (int i = 0; i < 54; i++) begin
      bus.pix_x = 10'(99 + (i % 52));
      @(negedge clk); cnt += int'(bus.in_box);
      @(posedge clk); #1;
    end
    chk("sweep row150", 32'(cnt), 0);

    // 6: reset in the middle of FADE
    do_slice(200, 200, 0);
    bus.pix_x = 10'd220; bus.pix_y = 9'd220;
    do_ticks(48);
    resetn = 0; step();
    chk("midreset active", 32'(bus.active), 0);
    chk("midreset in_box", 32'(bus.in_box), 0);
    chk("midreset splash_y", 32'(bus.splash_y), 0);
    resetn = 1; step();

    // random traffic
    for (int c = 0; c < 6000; c++) begin
      bus.slice = ($urandom_range(0, 149) == 0);
      bus.frame_tick = ($urandom_range(0, 2) == 0);
      bus.slice_x = 10'($urandom_range(0, 1023));
      bus.slice_y = 9'($urandom_range(0, 511));
      if ($urandom_range(0, 1) == 0) begin
        bus.pix_x = 10'(m_x + $urandom_range(0, 52) - 1);
        bus.pix_y = 9'(m_y() + $urandom_range(0, 52) - 1);
      end else begin
        bus.pix_x = 10'($urandom_range(0, 1023));
        bus.pix_y = 9'($urandom_range(0, 511));
      end
      resetn = ($urandom_range(0, 999) != 0);
      @(posedge clk); #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
